// File: rtl/cr_xer_write_arbiter_pkg.sv
// Shared types for the CR/XER side-effect write arbiter: update payload,
// XER SPR address and the XER field merge helper.
package cr_xer_write_arbiter_pkg;

    typedef struct packed {
        logic [0:2] cr_field;
        logic       lt;
        logic       gt;
        logic       eq;
        logic       so;
        logic       ov;
        logic       ca;
        logic       alter_cr;
        logic       alter_xer;
        logic       alter_ov;
        logic       alter_ca;
        logic       set_so;
    } cr_xer_update_t;

    localparam int         UPD_WIDTH    = $bits(cr_xer_update_t);
    localparam logic [9:0] XER_SPR_ADDR = 10'd1;

    // XER is big-endian numbered: bit 0 = SO, bit 1 = OV, bit 2 = CA.
    function automatic logic [0:31] xer_merge(input cr_xer_update_t u, input logic [0:31] cur);
        logic [0:31] v;
        v      = cur;
        v[0]   = u.set_so ? (cur[0] | u.ov) : u.so;
        v[1]   = u.alter_ov ? u.ov : cur[1];
        v[2]   = u.alter_ca ? u.ca : cur[2];
        return v;
    endfunction

endpackage

// File: rtl/cr_xer_write_arbiter_rr_grant.sv
// Combinational round-robin picker: one-hot grant to the first requester at
// or after ptr, wrapping from N-1 back to 0.
module rr_grant #(
    parameter  int N  = 5,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cr_xer_write_arbiter.sv
// Round-robin arbiter that funnels execution-unit CR/XER side effects into a
// single registered stage driving cond_reg_file and the XER write path.
module cr_xer_write_arbiter
    import cr_xer_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 5,
    parameter int RS_ID_WIDTH = 6
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][RS_ID_WIDTH-1:0]   req_rs_id,
    input  logic [NUM_REQ-1:0][UPD_WIDTH-1:0]     req_upd,
    input  logic [0:31]                           xer_current,
    output logic [0:7]                            cr_write_enable,
    output logic [0:31]                           cr_write_value,
    output logic [0:7][RS_ID_WIDTH-1:0]           cr_write_rs_id,
    output logic                                  xer_write_valid,
    input  logic                                  xer_write_ready,
    output logic [RS_ID_WIDTH-1:0]                xer_write_rs_id,
    output logic [0:31]                           xer_write_value
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [0:7]                  cr_en_q, cr_en_d;
    logic [0:31]                 cr_val_q, cr_val_d;
    logic [0:7][RS_ID_WIDTH-1:0] cr_rs_q, cr_rs_d;
    logic                        xer_valid_q, xer_valid_d;
    logic [RS_ID_WIDTH-1:0]      xer_rs_q, xer_rs_d;
    logic [0:31]                 xer_val_q, xer_val_d;

    logic [NUM_REQ-1:0] grant;
    logic               stage_free;
    logic               accept;

    rr_grant #(.N(NUM_REQ)) u_rr_grant (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    // Only a pending XER write can block the stage; the CR sink never stalls.
    assign stage_free = !xer_valid_q || xer_write_ready;
    assign req_ready  = (rst && stage_free) ? grant : '0;
    assign accept     = |(req_valid & req_ready);

    always_comb begin
        cr_xer_update_t         win_upd;
        logic [RS_ID_WIDTH-1:0] win_rs;
        int                     win_idx;
        int                     f;
        win_upd = '0;
        win_rs  = '0;
        win_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_upd = cr_xer_update_t'(req_upd[i]);
                win_rs  = req_rs_id[i];
                win_idx = i;
            end
        end
        f = int'(win_upd.cr_field);

        rr_ptr_d    = rr_ptr_q;
        cr_en_d     = '0;
        cr_val_d    = '0;
        cr_rs_d     = '0;
        xer_valid_d = xer_valid_q && !xer_write_ready;
        xer_rs_d    = xer_valid_d ? xer_rs_q  : '0;
        xer_val_d   = xer_valid_d ? xer_val_q : '0;

        if (accept) begin
            rr_ptr_d = (win_idx == NUM_REQ - 1) ? '0 : PW'(win_idx + 1);
            if (win_upd.alter_cr) begin
                cr_en_d[f]          = 1'b1;
                cr_val_d[4*f +: 4]  = {win_upd.lt, win_upd.gt, win_upd.eq, win_upd.so};
                cr_rs_d[f]          = win_rs;
            end
            if (win_upd.alter_xer) begin
                xer_valid_d = 1'b1;
                xer_rs_d    = win_rs;
                xer_val_d   = xer_merge(win_upd, xer_current);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            cr_en_q     <= '0;
            cr_val_q    <= '0;
            cr_rs_q     <= '0;
            xer_valid_q <= 1'b0;
            xer_rs_q    <= '0;
            xer_val_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cr_en_q     <= cr_en_d;
            cr_val_q    <= cr_val_d;
            cr_rs_q     <= cr_rs_d;
            xer_valid_q <= xer_valid_d;
            xer_rs_q    <= xer_rs_d;
            xer_val_q   <= xer_val_d;
        end
    end

    assign cr_write_enable = cr_en_q;
    assign cr_write_value  = cr_val_q;
    assign cr_write_rs_id  = cr_rs_q;
    assign xer_write_valid = xer_valid_q;
    assign xer_write_rs_id = xer_rs_q;
    assign xer_write_value = xer_val_q;

endmodule

// File: tb/tb_cr_xer_write_arbiter.sv
// Directed bench for cr_xer_write_arbiter: reset, CR write, fairness, XER
// stall, XER merge, null request and reset while stalled.
module tb_cr_xer_write_arbiter;
    import cr_xer_write_arbiter_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [4:0]                req_valid;
    logic [4:0]                req_ready;
    logic [4:0][5:0]           req_rs_id;
    logic [4:0][UPD_WIDTH-1:0] req_upd;
    logic [0:31]               xer_current;
    logic [0:7]                cr_write_enable;
    logic [0:31]               cr_write_value;
    logic [0:7][5:0]           cr_write_rs_id;
    logic                      xer_write_valid;
    logic                      xer_write_ready;
    logic [5:0]                xer_write_rs_id;
    logic [0:31]               xer_write_value;

    int tests = 0;
    int fails = 0;

    cr_xer_write_arbiter #(.NUM_REQ(5), .RS_ID_WIDTH(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rs_id       (req_rs_id),
        .req_upd         (req_upd),
        .xer_current     (xer_current),
        .cr_write_enable (cr_write_enable),
        .cr_write_value  (cr_write_value),
        .cr_write_rs_id  (cr_write_rs_id),
        .xer_write_valid (xer_write_valid),
        .xer_write_ready (xer_write_ready),
        .xer_write_rs_id (xer_write_rs_id),
        .xer_write_value (xer_write_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cr_xer_update_t mk(input logic [2:0] f, input logic [3:0] crb,
                                          input logic so, input logic ov, input logic ca,
                                          input logic acr, input logic axer, input logic aov,
                                          input logic aca, input logic sso);
        cr_xer_update_t u;
        u.cr_field  = f;
        {u.lt, u.gt, u.eq} = crb[3:1];
        u.so        = so | crb[0];
        u.ov        = ov;
        u.ca        = ca;
        u.alter_cr  = acr;
        u.alter_xer = axer;
        u.alter_ov  = aov;
        u.alter_ca  = aca;
        u.set_so    = sso;
        return u;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_cr_en"},   64'(cr_write_enable), 64'h0);
        chk({tag, "_cr_val"},  64'(cr_write_value),  64'h0);
        chk({tag, "_cr_rs"},   64'(cr_write_rs_id),  64'h0);
        chk({tag, "_xer_vld"}, 64'(xer_write_valid), 64'h0);
        chk({tag, "_xer_rs"},  64'(xer_write_rs_id), 64'h0);
        chk({tag, "_xer_val"}, 64'(xer_write_value), 64'h0);
    endtask

    initial begin
        logic [0:7][5:0] exp_rs;
        logic [4:0]      exp_ready;
        logic [0:7]      exp_en;

        rst             = 1'b0;
        req_valid       = '0;
        req_rs_id       = '0;
        req_upd         = '0;
        xer_current     = '0;
        xer_write_ready = 1'b0;

        // Reset state
        #1;
        chk_idle("reset");
        chk("reset_ready", 64'(req_ready), 64'h0);
        tick();
        tick();
        rst = 1'b1;

        // Single CR update from req2, field 3, LT/GT/EQ/SO = 1010, rs 9
        tick();
        req_valid    = 5'b00100;
        req_rs_id[2] = 6'd9;
        req_upd[2]   = mk(3'd3, 4'b1010, 0, 0, 0, 1, 0, 0, 0, 0);
        #1;
        chk("cr_single_ready", 64'(req_ready), 64'b00100);
        tick();
        req_valid = '0;
        #1;
        exp_rs    = '0;
        exp_rs[3] = 6'd9;
        chk("cr_single_en",    64'(cr_write_enable), 64'b0001_0000);
        chk("cr_single_val",   64'(cr_write_value),  64'h000A_0000);
        chk("cr_single_rs",    64'(cr_write_rs_id),  64'(exp_rs));
        chk("cr_single_noxer", 64'(xer_write_valid), 64'h0);
        tick();
        chk("cr_single_once",  64'(cr_write_enable), 64'h0);

        // Null request from req4 (rr_ptr is now 3)
        req_valid    = 5'b10000;
        req_rs_id[4] = 6'd33;
        req_upd[4]   = mk(3'd6, 4'b1111, 0, 1, 1, 0, 0, 1, 1, 1);
        #1;
        chk("null_ready", 64'(req_ready), 64'b10000);
        tick();
        req_valid = '0;
        #1;
        chk("null_no_cr",  64'(cr_write_enable), 64'h0);
        chk("null_no_xer", 64'(xer_write_valid), 64'h0);

        // Fairness: all five held valid for 10 cycles, rr_ptr starts at 0
        for (int i = 0; i < 5; i++) begin
            req_rs_id[i] = 6'(10 + i);
            req_upd[i]   = mk(3'(i), 4'b1000, 0, 0, 0, 1, 0, 0, 0, 0);
        end
        req_valid = 5'b11111;
        #1;
        for (int k = 0; k < 10; k++) begin
            exp_ready = 5'(1 << (k % 5));
            chk($sformatf("fair_grant%0d", k), 64'(req_ready), 64'(exp_ready));
            if (k > 0) begin
                exp_en = 8'(8'h80 >> ((k - 1) % 5));
                chk($sformatf("fair_cr_en%0d", k), 64'(cr_write_enable), 64'(exp_en));
            end
            tick();
        end
        req_valid = '0;
        #1;
        chk("fair_cr_en_last", 64'(cr_write_enable), 64'h08);
        chk("fair_cr_rs_last", 64'(cr_write_rs_id[4]), 64'd14);

        // XER stall: req1 sets CA, sink not ready for 3 cycles; req3 waits
        xer_current     = '0;
        xer_write_ready = 1'b0;
        req_valid       = 5'b00010;
        req_rs_id[1]    = 6'd21;
        req_upd[1]      = mk(3'd0, 4'b0000, 0, 0, 1, 0, 1, 0, 1, 0);
        #1;
        chk("stall_first_ready", 64'(req_ready), 64'b00010);
        tick();
        req_valid    = 5'b01000;
        req_rs_id[3] = 6'd23;
        req_upd[3]   = mk(3'd5, 4'b0100, 0, 0, 0, 1, 0, 0, 0, 0);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall_vld%0d", c),   64'(xer_write_valid), 64'h1);
            chk($sformatf("stall_val%0d", c),   64'(xer_write_value), 64'h2000_0000);
            chk($sformatf("stall_rs%0d", c),    64'(xer_write_rs_id), 64'd21);
            chk($sformatf("stall_ready%0d", c), 64'(req_ready),       64'h0);
            if (c < 2) tick();
        end
        xer_write_ready = 1'b1;
        #1;
        chk("stall_resume_ready", 64'(req_ready), 64'b01000);
        tick();
        xer_write_ready = 1'b0;
        req_valid       = '0;
        #1;
        chk("stall_cleared",    64'(xer_write_valid),   64'h0);
        chk("stall_next_cr_en", 64'(cr_write_enable),   64'b0000_0100);
        chk("stall_next_cr_rs", 64'(cr_write_rs_id[5]), 64'd23);

        // XER merge: SO from old SO | ov, OV from payload, CA kept from current
        xer_current     = 32'h8000_007F;
        xer_write_ready = 1'b1;
        req_valid       = 5'b00001;
        req_rs_id[0]    = 6'd40;
        req_upd[0]      = mk(3'd0, 4'b0000, 0, 1, 1, 0, 1, 1, 0, 1);
        #1;
        chk("merge_ready", 64'(req_ready), 64'b00001);
        tick();
        req_valid   = '0;
        xer_current = 32'h0000_0000;
        #1;
        chk("merge_vld",   64'(xer_write_valid), 64'h1);
        chk("merge_val",   64'(xer_write_value), 64'hC000_007F);
        chk("merge_rs",    64'(xer_write_rs_id), 64'd40);
        chk("merge_no_cr", 64'(cr_write_enable), 64'h0);
        tick();
        chk("merge_done", 64'(xer_write_valid), 64'h0);

        // Reset while stalled: req2 XER write pending, then rst pulses low
        xer_write_ready = 1'b0;
        req_valid       = 5'b00100;
        req_upd[2]      = mk(3'd1, 4'b1100, 0, 0, 1, 1, 1, 0, 1, 0);
        #1;
        chk("rst_pre_ready", 64'(req_ready), 64'b00100);
        tick();
        req_valid = 5'b01001;
        req_upd[0] = mk(3'd2, 4'b0010, 0, 0, 0, 1, 0, 0, 0, 0);
        req_upd[3] = mk(3'd7, 4'b0001, 0, 0, 0, 1, 0, 0, 0, 0);
        #1;
        chk("rst_pre_stall", 64'(xer_write_valid), 64'h1);
        rst = 1'b0;
        #1;
        chk_idle("rst_async");
        chk("rst_async_ready", 64'(req_ready), 64'h0);
        tick();
        chk_idle("rst_held");
        rst = 1'b1;
        #1;
        chk("rst_first_grant", 64'(req_ready), 64'b00001);
        tick();
        req_valid = '0;
        #1;
        chk("rst_first_cr_en", 64'(cr_write_enable), 64'b0010_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
